// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - FP32 field widths, constants and helpers shared by the adder pipeline
package fp_add_pkg;

  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int STAGES  = 3;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  // Leading-zero count of a 27-bit significand; 27 when the value is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_add_lane.sv
// rtl/fp_add_lane.sv - one FP32 add/sub lane, 3 register stages; IEEE specials when FP_ADD_SPECIAL_EN is defined
module fp_add_lane
  import fp_add_pkg::*;
(
  input  logic        clock,
  input  logic        aclr,
  input  logic        adv,
  input  logic        sub,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  // ---------------- S1: unpack, flush, swap, align ----------------
  fp_t         w_a, w_b;
  logic        w_a_zero, w_b_zero, w_sb_eff, w_swap;
  logic [23:0] w_ma, w_mb, w_big_m, w_sml_m;
  logic [7:0]  w_big_exp, w_sml_exp, w_shift;
  logic        w_big_sign, w_sml_sign;
  logic [26:0] w_sml_ext, w_shifted, w_lost, w_aligned;

  assign w_a        = dataa;
  assign w_b        = datab;
  assign w_a_zero   = (w_a.exp == '0);
  assign w_b_zero   = (w_b.exp == '0);
  assign w_sb_eff   = w_b.sign ^ sub;
  assign w_ma       = w_a_zero ? 24'd0 : {1'b1, w_a.frac};
  assign w_mb       = w_b_zero ? 24'd0 : {1'b1, w_b.frac};
  assign w_swap     = {w_b.exp, w_b.frac} > {w_a.exp, w_a.frac};
  assign w_big_exp  = w_swap ? w_b.exp : w_a.exp;
  assign w_sml_exp  = w_swap ? w_a.exp : w_b.exp;
  assign w_big_m    = w_swap ? w_mb : w_ma;
  assign w_sml_m    = w_swap ? w_ma : w_mb;
  assign w_big_sign = w_swap ? w_sb_eff : w_a.sign;
  assign w_sml_sign = w_swap ? w_a.sign : w_sb_eff;
  assign w_shift    = w_big_exp - w_sml_exp;
  assign w_sml_ext  = {w_sml_m, 3'b000};

  // Right-align the smaller significand, folding shifted-out bits into sticky
  always_comb begin
    w_shifted = '0;
    w_lost    = '0;
    w_aligned = '0;
    if (w_shift >= 8'd26) begin
      w_aligned = {26'd0, |w_sml_m};
    end else begin
      w_shifted = w_sml_ext >> w_shift;
      w_lost    = w_sml_ext & ~(27'h7FF_FFFF << w_shift);
      w_aligned = {w_shifted[26:1], w_shifted[0] | (|w_lost)};
    end
  end

  logic        r1_sign, r1_eff_sub, r1_zero_sign;
  logic [7:0]  r1_exp;
  logic [26:0] r1_big, r1_sml;

  // S1 register
  always_ff @(posedge clock) begin
    if (aclr) begin
      r1_sign      <= 1'b0;
      r1_eff_sub   <= 1'b0;
      r1_zero_sign <= 1'b0;
      r1_exp       <= '0;
      r1_big       <= '0;
      r1_sml       <= '0;
    end else if (adv) begin
      r1_sign      <= w_big_sign;
      r1_eff_sub   <= w_big_sign ^ w_sml_sign;
      r1_zero_sign <= w_a_zero & w_b_zero & w_a.sign & w_sb_eff;
      r1_exp       <= w_big_exp;
      r1_big       <= {w_big_m, 3'b000};
      r1_sml       <= w_aligned;
    end
  end

  // ---------------- S2: add / subtract magnitudes ----------------
  logic [27:0] w_sum;
  assign w_sum = r1_eff_sub ? ({1'b0, r1_big} - {1'b0, r1_sml})
                            : ({1'b0, r1_big} + {1'b0, r1_sml});

  logic        r2_sign, r2_zero_sign;
  logic [7:0]  r2_exp;
  logic [27:0] r2_sum;

  // S2 register
  always_ff @(posedge clock) begin
    if (aclr) begin
      r2_sign      <= 1'b0;
      r2_zero_sign <= 1'b0;
      r2_exp       <= '0;
      r2_sum       <= '0;
    end else if (adv) begin
      r2_sign      <= r1_sign;
      r2_zero_sign <= r1_zero_sign;
      r2_exp       <= r1_exp;
      r2_sum       <= w_sum;
    end
  end

  // ---------------- S3: normalize, round to nearest even, pack ----------------
  logic [4:0]         w_lz;
  logic [26:0]        w_norm;
  logic signed [9:0]  w_exp_n, w_exp_r;
  logic               w_inc;
  logic [24:0]        w_mant;
  logic [22:0]        w_frac;
  logic [31:0]        w_res;

  assign w_lz = lzc27(r2_sum[26:0]);

`ifdef FP_ADD_SPECIAL_EN
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_spec;
  logic [31:0] w_spec_val;
  logic        r1_spec, r2_spec;
  logic [31:0] r1_spec_val, r2_spec_val;

  assign w_a_inf = (w_a.exp == 8'hFF) && (w_a.frac == '0);
  assign w_b_inf = (w_b.exp == 8'hFF) && (w_b.frac == '0);
  assign w_a_nan = (w_a.exp == 8'hFF) && (w_a.frac != '0);
  assign w_b_nan = (w_b.exp == 8'hFF) && (w_b.frac != '0);
  assign w_spec  = (w_a.exp == 8'hFF) || (w_b.exp == 8'hFF);

  // Result for any operand set containing an Inf or NaN
  always_comb begin
    w_spec_val = QNAN;
    if (w_a_nan || w_b_nan)     w_spec_val = QNAN;
    else if (w_a_inf && w_b_inf) w_spec_val = (w_a.sign != w_sb_eff) ? QNAN : {w_a.sign, 8'hFF, 23'd0};
    else if (w_a_inf)           w_spec_val = {w_a.sign, 8'hFF, 23'd0};
    else                        w_spec_val = {w_sb_eff, 8'hFF, 23'd0};
  end

  // Carry the special-case override alongside S1 and S2
  always_ff @(posedge clock) begin
    if (aclr) begin
      r1_spec     <= 1'b0;
      r1_spec_val <= '0;
      r2_spec     <= 1'b0;
      r2_spec_val <= '0;
    end else if (adv) begin
      r1_spec     <= w_spec;
      r1_spec_val <= w_spec_val;
      r2_spec     <= r1_spec;
      r2_spec_val <= r1_spec_val;
    end
  end
`endif

  // Normalize, round and select zero / underflow / overflow / normal encodings
  always_comb begin
    w_norm  = '0;
    w_exp_n = '0;
    if (r2_sum[27]) begin
      w_norm  = {r2_sum[27:2], r2_sum[1] | r2_sum[0]};
      w_exp_n = {2'b00, r2_exp} + 10'd1;
    end else begin
      w_norm  = r2_sum[26:0] << w_lz;
      w_exp_n = {2'b00, r2_exp} - {5'd0, w_lz};
    end
    w_inc   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant  = {1'b0, w_norm[26:3]} + {24'd0, w_inc};
    w_exp_r = w_exp_n + {9'd0, w_mant[24]};
    w_frac  = w_mant[24] ? w_mant[23:1] : w_mant[22:0];
    if (r2_sum == '0)                          w_res = {r2_zero_sign, 31'd0};
    else if (w_exp_r <= 10'sd0)                w_res = 32'd0;
    else if (w_exp_r >= $signed(10'(EXP_MAX))) w_res = {r2_sign, 8'hFF, 23'd0};
    else                                       w_res = {r2_sign, w_exp_r[7:0], w_frac};
`ifdef FP_ADD_SPECIAL_EN
    if (r2_spec) w_res = r2_spec_val;
`endif
  end

  // S3 register drives the lane result
  always_ff @(posedge clock) begin
    if (aclr)     result <= '0;
    else if (adv) result <= w_res;
  end

endmodule

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - LANES-wide FP32 add/sub pipeline with valid/ready flow control (option: FP_ADD_SPECIAL_EN)
module fp_add_pipe
  import fp_add_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                clock,
  input  logic                aclr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sub,
  input  logic [32*LANES-1:0] dataa,
  input  logic [32*LANES-1:0] datab,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] result
);

  logic              w_adv;
  logic [STAGES-1:0] r_valid;

  // The whole pipe moves only when the output slot is free or being drained
  assign w_adv     = out_ready | ~r_valid[STAGES-1];
  assign in_ready  = w_adv;
  assign out_valid = r_valid[STAGES-1];

  // Stage valid bits shift with the datapath; bubbles travel as 0
  always_ff @(posedge clock) begin
    if (aclr)       r_valid <= '0;
    else if (w_adv) r_valid <= {r_valid[STAGES-2:0], in_valid};
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_add_lane u_lane (
      .clock  (clock),
      .aclr   (aclr),
      .adv    (w_adv),
      .sub    (sub),
      .dataa  (dataa[32*i +: 32]),
      .datab  (datab[32*i +: 32]),
      .result (result[32*i +: 32])
    );
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - directed self-checking bench for fp_add_pipe (LANES=1 and LANES=4 instances)
module tb_fp_add_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         aclr;
  logic         iv1, ir1, sub1, ov1, or1;
  logic [31:0]  a1, b1, r1;
  logic         iv4, ir4, sub4, ov4, or4;
  logic [127:0] a4, b4, r4;

  int n_tests = 0;
  int n_fail  = 0;

  fp_add_pipe #(.LANES(1)) u_dut1 (
    .clock(clock), .aclr(aclr), .in_valid(iv1), .in_ready(ir1), .sub(sub1),
    .dataa(a1), .datab(b1), .out_valid(ov1), .out_ready(or1), .result(r1)
  );

  fp_add_pipe #(.LANES(4)) u_dut4 (
    .clock(clock), .aclr(aclr), .in_valid(iv4), .in_ready(ir4), .sub(sub4),
    .dataa(a4), .datab(b4), .out_valid(ov4), .out_ready(or4), .result(r4)
  );

  // Directed vectors: a, b, sub, hand-computed result
  localparam int NV = 17;
  logic [31:0] tv_a [NV] = '{32'h41700000, 32'h41700000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h7F7FFFFF, 32'hFF7FFFFF, 32'h80000000, 32'h00000001, 32'h80400000,
                             32'h4C800000, 32'h4C800000, 32'h00800000, 32'hBF800000, 32'h40000000,
                             32'h4B800000, 32'h3F800000};
  logic [31:0] tv_b [NV] = '{32'h40800000, 32'h40800000, 32'h3F800000, 32'h33800000, 32'h33C00000,
                             32'h7F7FFFFF, 32'hFF7FFFFF, 32'h80000000, 32'h3F800000, 32'h00000000,
                             32'h3FFFFFFF, 32'h3F800000, 32'h00800001, 32'h3F800000, 32'hBF800000,
                             32'h3F800000, 32'h40000000};
  logic        tv_s [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] tv_e [NV] = '{32'h41980000, 32'h41300000, 32'h00000000, 32'h3F800000, 32'h3F800001,
                             32'h7F800000, 32'hFF800000, 32'h80000000, 32'h3F800000, 32'h00000000,
                             32'h4C800000, 32'h4C800000, 32'h00000000, 32'h00000000, 32'h3F800000,
                             32'h4B800000, 32'hBF800000};

  // Exact FP32 encoding of a positive integer below 2^24
  function automatic logic [31:0] int2fp(input int n);
    int m;
    m = 0;
    if (n == 0) return 32'd0;
    for (int i = 0; i < 24; i++) if (n[i]) m = i;
    return {1'b0, 8'(127 + m), 23'((n << (23 - m)) & 32'h7FFFFF)};
  endfunction

  // Single transaction on the 1-lane DUT; lat counts rising edges from the accepting one
  task automatic xact1(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] res, output int lat);
    @(negedge clock);
    iv1 = 1'b1; a1 = a; b1 = b; sub1 = s;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    iv1 = 1'b0;
    while (lat < 10 && ov1 !== 1'b1) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    res = r1;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_ov1 got %b expected 0", ov1); end
    n_tests++; if (r1 !== 32'd0) begin n_fail++; $display("FAIL reset_r1 got %h expected 0", r1); end
    n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_ov4 got %b expected 0", ov4); end
    n_tests++; if (r4 !== 128'd0) begin n_fail++; $display("FAIL reset_r4 got %h expected 0", r4); end
    aclr = 1'b0;
    #1;
    n_tests++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL reset_ir1 got %b expected 1", ir1); end
    n_tests++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL reset_ir4 got %b expected 1", ir4); end
  endtask

  task automatic test_arith();
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < NV; i++) begin
      xact1(tv_a[i], tv_b[i], tv_s[i], res, lat);
      n_tests++;
      if (lat != 3) begin n_fail++; $display("FAIL arith[%0d] latency got %0d expected 3", i, lat); end
      n_tests++;
      if (res !== tv_e[i]) begin n_fail++; $display("FAIL arith[%0d] result got %h expected %h", i, res, tv_e[i]); end
    end
  endtask

`ifdef FP_ADD_SPECIAL_EN
  task automatic test_special();
    logic [31:0] sa [4] = '{32'h7F800000, 32'h7FC00001, 32'h7F800000, 32'h3F800000};
    logic [31:0] sb [4] = '{32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h7F800000};
    logic        ss [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] se [4] = '{32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'hFF800000};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      xact1(sa[i], sb[i], ss[i], res, lat);
      n_tests++;
      if (res !== se[i]) begin n_fail++; $display("FAIL special[%0d] result got %h expected %h", i, res, se[i]); end
    end
  endtask
`endif

  // Three back-to-back transactions, a bubble, then one more
  task automatic test_back_to_back();
    int   drv [10] = '{0, 1, 3, -1, 4, -1, -1, -1, -1, -1};
    logic expv;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (drv[c] >= 0) begin
        iv1 = 1'b1; a1 = tv_a[drv[c]]; b1 = tv_b[drv[c]]; sub1 = tv_s[drv[c]];
      end else begin
        iv1 = 1'b0;
      end
      #1;
      expv = (c >= 3) && (drv[(c >= 3) ? c - 3 : 0] >= 0);
      n_tests++;
      if (ov1 !== expv) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b expected %b", c, ov1, expv); end
      if (expv) begin
        n_tests++;
        if (r1 !== tv_e[drv[c - 3]]) begin
          n_fail++; $display("FAIL b2b_result[%0d] got %h expected %h", c, r1, tv_e[drv[c - 3]]);
        end
      end
    end
    iv1 = 1'b0;
  endtask

  // 6 transactions on the 4-lane DUT with out_ready low for cycles 5..8
  task automatic test_backpressure();
    logic [127:0] exp4 [6];
    int           tidx, nout, vs;
    logic         acc;
    tidx = 0; nout = 0;
    for (int t = 0; t < 6; t++)
      for (int i = 0; i < 4; i++) begin
        vs = t[0] ? (t + 10 - (i + 1)) : (t + 10 + (i + 1));
        exp4[t][32*i +: 32] = int2fp(vs);
      end
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (tidx < 6) begin
        iv4 = 1'b1; sub4 = tidx[0];
        for (int i = 0; i < 4; i++) begin
          a4[32*i +: 32] = int2fp(tidx + 10);
          b4[32*i +: 32] = int2fp(i + 1);
        end
      end else begin
        iv4 = 1'b0;
      end
      or4 = !(c >= 5 && c <= 8);
      #1;
      if (c >= 5 && c <= 8) begin
        n_tests++;
        if (ir4 !== 1'b0) begin n_fail++; $display("FAIL bp_stall_in_ready[%0d] got %b expected 0", c, ir4); end
      end
      if (ov4 === 1'b1 && or4) begin
        n_tests++;
        if (nout >= 6) begin
          n_fail++; $display("FAIL bp_extra_result got %h expected none", r4);
        end else if (r4 !== exp4[nout]) begin
          n_fail++; $display("FAIL bp_result[%0d] got %h expected %h", nout, r4, exp4[nout]);
        end
        nout++;
      end
      acc = iv4 && (ir4 === 1'b1);
      @(posedge clock);
      if (acc) tidx++;
    end
    iv4 = 1'b0; or4 = 1'b1;
    n_tests++; if (nout != 6) begin n_fail++; $display("FAIL bp_count got %0d expected 6", nout); end
    n_tests++; if (tidx != 6) begin n_fail++; $display("FAIL bp_accepted got %0d expected 6", tidx); end
  endtask

  // Reset with two transactions in flight; nothing may emerge afterwards
  task automatic test_reset_midstream();
    @(negedge clock);
    iv1 = 1'b1; a1 = tv_a[0]; b1 = tv_b[0]; sub1 = 1'b0;
    @(negedge clock);
    a1 = tv_a[14]; b1 = tv_b[14];
    @(negedge clock);
    iv1 = 1'b0; aclr = 1'b1;
    @(negedge clock);
    aclr = 1'b0;
    #1;
    n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL midrst_ov got %b expected 0", ov1); end
    n_tests++; if (r1 !== 32'd0) begin n_fail++; $display("FAIL midrst_result got %h expected 0", r1); end
    n_tests++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b expected 1", ir1); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      n_tests++;
      if (ov1 !== 1'b0) begin n_fail++; $display("FAIL midrst_stale[%0d] got %b expected 0", c, ov1); end
    end
  endtask

  initial begin
    aclr = 1'b1;
    iv1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; or1 = 1'b1;
    iv4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
    test_reset();
    test_arith();
`ifdef FP_ADD_SPECIAL_EN
    test_special();
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 The module SHALL have parameter LANES, default 1, giving the number of independent FP32 adder lanes (1..8).
REQ-002 The module SHALL have port clock, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port aclr, input, 1 bit, a reset that is synchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit, meaning an operand set is offered.
REQ-005 The module SHALL have port in_ready, output, 1 bit, meaning an operand set is accepted this cycle.
REQ-006 The module SHALL have port sub, input, 1 bit, meaning compute dataa-datab for all lanes of this transaction; 0 means dataa+datab.
REQ-007 The module SHALL have port dataa, input, 32*LANES bits, holding lane i operand A in bits [32i+31:32i], IEEE-754 binary32.
REQ-008 The module SHALL have port datab, input, 32*LANES bits, holding lane i operand B with the same packing.
REQ-009 The module SHALL have port out_valid, output, 1 bit, meaning result holds a completed transaction.
REQ-010 The module SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result this cycle.
REQ-011 The module SHALL have port result, output, 32*LANES bits, holding the per-lane sums with the same packing.

Function
REQ-012 The datapath SHALL have exactly 3 register stages: S1 unpack/swap/align, S2 add/subtract, S3 normalize/round/pack.
REQ-013 The module SHALL compute adv = out_ready | ~out_valid, drive in_ready = adv, and shift all stages together only when adv=1.
REQ-014 With adv held at 1, a transaction accepted at edge N SHALL appear on result with out_valid=1 after edge N+3.
REQ-015 When adv=0, every stage register, result and out_valid SHALL hold their values; in_valid SHALL be ignored.
REQ-016 A bubble (in_valid=0 while adv=1) SHALL propagate as an invalid stage; back-to-back transactions SHALL sustain 1 per cycle.
REQ-017 Rounding SHALL be round-to-nearest-even, using guard, round and sticky bits retained through alignment.
REQ-018 An input with exponent 0 SHALL be flushed to a zero of the same sign; a result below 2^-126 after rounding SHALL be +0.
REQ-019 A result exponent overflow SHALL produce +/-Inf (0x7F800000 or 0xFF800000).
REQ-020 Exact cancellation SHALL return +0; (-0)+(-0) SHALL return -0.
REQ-021 Alignment shifts of 26 or more SHALL reduce the smaller operand to sticky only.
REQ-022 Lanes SHALL be computationally independent and share only the valid/stall control.

Reset
REQ-023 While aclr=1 at a clock edge, out_valid and all stage valid bits SHALL clear to 0 and result SHALL clear to 0.
REQ-024 A reset asserted mid-operation SHALL discard in-flight transactions, and none of them SHALL emerge afterwards.
REQ-025 in_ready SHALL equal 1 in the first cycle after reset releases.

Configuration
REQ-026 With macro FP_ADD_SPECIAL_EN defined, exponent-255 inputs SHALL follow IEEE rules: NaN in gives 0x7FC00000, Inf-Inf gives 0x7FC00000, Inf+finite gives that Inf.
REQ-027 Without FP_ADD_SPECIAL_EN, exponent-255 inputs SHALL be outside contract, with unspecified result but correct handshake, and no special-case logic SHALL be synthesized.

Structure
REQ-028 Package fp_add_pkg SHALL hold the FP32 field widths (1/8/23), the bias of 127, EXP_MAX of 255, the QNAN constant 0x7FC00000 and the stage-count constant 3.
REQ-029 The per-lane 3-stage datapath SHALL be sub-module fp_add_lane, instantiated LANES times; fp_add_pipe SHALL own the valid/adv control.

Verification
REQ-030 LANES=1, 0x41700000 + 0x40800000 with sub=0 -> result 0x41980000 (19.0) with out_valid exactly 3 cycles after acceptance.
REQ-031 Same operands with sub=1 -> 0x41300000 (11.0); 0x3F800000 - 0x3F800000 -> 0x00000000.
REQ-032 Rounding: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even); 0x3F800000 + 0x33C00000 -> 0x3F800001.
REQ-033 Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; with FP_ADD_SPECIAL_EN, 0x7F800000 + 0xFF800000 -> 0x7FC00000.
REQ-034 Backpressure: with LANES=4, stream 6 transactions and hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the stall, no result lost or duplicated, and order preserved.
REQ-035 Reset mid-stream: assert aclr with 2 transactions in flight -> out_valid=0 and result=0 next cycle, and no stale result appears later.
